div_iter: RTL and testbench

Iterative radix-2 restoring divider for the EX stage. It answers the ALU's divide request (`div`) with a single-cycle `complete` pulse carrying the quotient `s` and remainder `r`. It covers DIV.W/DIV.WU/MOD.W/MOD.WU: signed or unsigned 32-bit operands, fixed 33-cycle latency from the request being sampled. The ALU holds the request and operands while the stage is stalled and releases the stall on `complete`.

---
 rtl/div_iter.sv | 68 ++++++
 tb/tb_div_iter.sv | 114 +++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, signed/unsigned 32-bit, fixed 33-cycle latency.
// Magnitudes are divided, then the signs are applied; divide by zero is overridden at DONE entry.
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div,
    input  logic        div_signed,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] s,
    output logic [31:0] r,
    output logic        complete
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_next;
    logic [31:0] r_rem, r_quo, r_dsr, r_x;
    logic [4:0]  r_cnt;
    logic        r_sign_q, r_sign_r, r_zero;
    logic [32:0] w_sh, w_t;
    logic [31:0] w_rem, w_quo, w_ax, w_ay;
    logic        w_last;
    assign w_ax = (x[31] & div_signed) ? -x : x;
    assign w_ay = (y[31] & div_signed) ? -y : y;
    // r_quo starts as the dividend; its MSB feeds the remainder while quotient bits fill from the LSB
    assign w_sh  = {r_rem, r_quo[31]};
    assign w_t   = w_sh - {1'b0, r_dsr};
    assign w_rem = w_t[32] ? w_sh[31:0] : w_t[31:0];
    assign w_quo = {r_quo[30:0], ~w_t[32]};
    assign w_last = r_cnt == 5'd31;
    assign complete = r_state == DONE;
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = div ? BUSY : IDLE;
            BUSY:    w_next = !div ? IDLE : (w_last ? DONE : BUSY);
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rem <= '0;
            r_cnt <= '0;
            s     <= '0;
            r     <= '0;
        end else if (r_state == IDLE && div) begin
            r_quo    <= w_ax;
            r_dsr    <= w_ay;
            r_x      <= x;
            r_zero   <= y == 32'd0;
            r_sign_q <= (x[31] ^ y[31]) & div_signed;
            r_sign_r <= x[31] & div_signed;
            r_rem    <= '0;
            r_cnt    <= '0;
        end else if (r_state == BUSY && div) begin
            r_rem <= w_rem;
            r_quo <= w_quo;
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
                s <= r_zero ? 32'hFFFF_FFFF : (r_sign_q ? -w_quo : w_quo);
                r <= r_zero ? r_x : (r_sign_r ? -w_rem : w_rem);
            end
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and randomized checks of div_iter against an arithmetic reference model.
module tb_div_iter;
    logic        clk = 0, resetn = 0, div = 0, div_signed = 0;
    logic [31:0] x = 0, y = 0, s, r;
    logic        complete;
    int          errors = 0, checks = 0;
    logic [31:0] last_s = 0, last_r = 0;

    div_iter dut (.clk(clk), .resetn(resetn), .div(div), .div_signed(div_signed),
                  .x(x), .y(y), .s(s), .r(r), .complete(complete));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint sa, sb, q, rm;
        if (b == 0) return {32'hFFFF_FFFF, a};
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        q  = sa / sb;
        rm = sa % sb;
        return {q[31:0], rm[31:0]};
    endfunction

    // lat: expected cycle count from the call's negedge to the complete pulse
    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic sg, input int lat);
        logic [63:0] e;
        int c;
        e = ref_div(a, b, sg);
        x = a; y = b; div_signed = sg; div = 1;
        c = 0;
        for (int i = 1; i <= 45 && c == 0; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 1 && lat == 33) begin
                x = $urandom; y = $urandom; div_signed = 1'($urandom);
            end
            if (complete) c = i;
        end
        chk("latency", c, lat);
        chk("quotient", s, e[63:32]);
        chk("remainder", r, e[31:0]);
        last_s = e[63:32];
        last_r = e[31:0];
    endtask

    task automatic fin;
        div = 0;
        @(negedge clk);
        chk("complete_after", {31'd0, complete}, 32'd0);
    endtask

    task automatic quiet(input int n);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
            if (complete) k++;
        end
        chk("no_complete", k, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_complete", {31'd0, complete}, 0);
        resetn = 1;
        @(negedge clk);
        op(32'd7, 32'd2, 0, 33); fin;
        op(32'hFFFF_FFF9, 32'd2, 1, 33); fin;
        op(32'd7, 32'hFFFF_FFFE, 1, 33); fin;
        op(32'hFFFF_FFFF, 32'h10, 0, 33); fin;
        op(32'h8000_0000, 32'hFFFF_FFFF, 1, 33); fin;
        op(32'h1234, 32'd0, 0, 33); fin;
        op(32'h1234, 32'd0, 1, 33); fin;
        op(32'd100, 32'd7, 0, 33);
        op(32'd50, 32'd5, 0, 34); fin;
        x = 32'd1000; y = 32'd3; div = 1;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        div = 0;
        quiet(40);
        chk("abort_s", s, last_s);
        chk("abort_r", r, last_r);
        op(32'd9, 32'd3, 0, 33); fin;
        x = 32'd1000; y = 32'd3; div = 1;
        repeat (20) begin @(posedge clk); @(negedge clk); end
        resetn = 0; div = 0;
        @(negedge clk);
        resetn = 1;
        chk("midrst_s", s, 0);
        chk("midrst_r", r, 0);
        chk("midrst_complete", {31'd0, complete}, 0);
        quiet(40);
        op(32'd9, 32'd3, 0, 33); fin;
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a, b;
            int m;
            a = $urandom;
            m = $urandom_range(0, 3);
            b = m == 0 ? 32'd0 : m == 1 ? 32'($urandom_range(1, 15)) :
                m == 2 ? -32'($urandom_range(1, 15)) : $urandom;
            op(a, b, 1'($urandom_range(0, 1)), 33); fin;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
